lfsr_gen: RTL and testbench

- Parametrised Fibonacci LFSR pseudo-random generator. It is the next generation of the fixed 4-bit table-lookup LFSR output stage.
- Generates the sequence directly from a tap mask at any width. It has an integrated tick divider, so no separate slow-clock module or clock-gated domain is needed.
- Adds seed load, single-step mode, all-zero lock-up protection, a step counter and a sequence-wrap flag.
- Sits between the board clock and display/test-pattern logic.

---
 rtl/lfsr_gen.sv | 104 ++++++++++
 tb/tb_lfsr_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci LFSR generator with tick divider, seed load, single-step and lock-up guard
module lfsr_gen #(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0]   SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int                 DIV   = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             tick,
  output logic [WIDTH-1:0] step_cnt,
  output logic             wrap,
  output logic             lockup
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [CW-1:0]    div_q, div_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic             div_expire;
  logic             adv;
  logic [WIDTH-1:0] adv_state;

  always_comb begin
    div_expire = en & ~mode & (div_q == DIV_LAST);
    adv        = mode ? (step & en) : div_expire;
    // A zero state can only arise from a non-maximal tap mask; recover to SEED.
    adv_state  = (lfsr_q == '0) ? SEED : {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    lfsr_d     = lfsr_q;
    start_d    = start_q;
    step_cnt_d = step_cnt_q;
    div_d      = div_q;
    tick_d     = div_expire;
    wrap_d     = 1'b0;
    lockup_d   = lockup_q;

    if (load || mode) begin
      div_d = '0;
    end else if (en) begin
      div_d = div_expire ? '0 : div_q + CW'(1);
    end

    if (load) begin
      step_cnt_d = '0;
      if (seed != '0) begin
        lfsr_d   = seed;
        start_d  = seed;
        lockup_d = 1'b0;
      end else begin
        lfsr_d   = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end
    end else if (adv) begin
      lfsr_d     = adv_state;
      step_cnt_d = step_cnt_q + WIDTH'(1);
      wrap_d     = (adv_state == start_q);
      if (lfsr_q == '0) begin
        lockup_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= SEED;
      start_q    <= SEED;
      step_cnt_q <= '0;
      div_q      <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      start_q    <= start_d;
      step_cnt_q <= step_cnt_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      lockup_q   <= lockup_d;
    end
  end

  assign lfsr_out = lfsr_q;
  assign tick     = tick_q;
  assign step_cnt = step_cnt_q;
  assign wrap     = wrap_q;
  assign lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen against an arithmetic reference model
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1, en = 1'b0, mode = 1'b0, step = 1'b0, load = 1'b0;
  logic [3:0] seed = 4'd0;
  logic [4:0] seed5 = 5'd1;

  logic [3:0] lfsr1, cnt1, lfsr4, cnt4;
  logic       tick1, wrap1, lock1, tick4, wrap4, lock4;
  logic [4:0] lfsr5, cnt5;
  logic       tick5, wrap5, lock5;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .step(step), .load(load), .seed(seed),
    .lfsr_out(lfsr1), .tick(tick1), .step_cnt(cnt1), .wrap(wrap1), .lockup(lock1));

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'd1), .DIV(4)) u_div4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .step(step), .load(load), .seed(seed),
    .lfsr_out(lfsr4), .tick(tick4), .step_cnt(cnt4), .wrap(wrap4), .lockup(lock4));

  lfsr_gen #(.WIDTH(5), .TAPS(5'b10100), .SEED(5'd1), .DIV(1)) u_w5 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .step(step), .load(load), .seed(seed5),
    .lfsr_out(lfsr5), .tick(tick5), .step_cnt(cnt5), .wrap(wrap5), .lockup(lock5));

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_seq [16] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                               4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};

  // Reference state for instance 0 (DIV=1) and instance 1 (DIV=4).
  logic [3:0] m_state [2];
  logic [3:0] m_start [2];
  logic [3:0] m_steps [2];
  int         m_cnt   [2];
  logic       m_tick  [2];
  logic       m_wrap  [2];
  logic       m_lock  [2];

  function automatic logic [3:0] succ4(input logic [3:0] s);
    int v;
    if (s == 4'd0) return 4'd1;
    v = (int'(s) * 2) % 16 + ($countones(s & 4'b1100) % 2);
    return 4'(v);
  endfunction

  function automatic logic [4:0] succ5(input logic [4:0] s);
    int v;
    v = (int'(s) * 2) % 32 + ($countones(s & 5'b10100) % 2);
    return 5'(v);
  endfunction

  task automatic clk_edge();
    int   div_n;
    logic expire, adv;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      div_n = (i == 0) ? 1 : 4;
      if (reset) begin
        m_state[i] = 4'd1; m_start[i] = 4'd1; m_steps[i] = 4'd0;
        m_cnt[i] = 0; m_tick[i] = 1'b0; m_wrap[i] = 1'b0; m_lock[i] = 1'b0;
      end else begin
        expire    = en && !mode && (m_cnt[i] == div_n - 1);
        m_tick[i] = expire;
        if (load || mode) m_cnt[i] = 0;
        else if (en) m_cnt[i] = expire ? 0 : m_cnt[i] + 1;
        adv       = mode ? (step && en) : expire;
        m_wrap[i] = 1'b0;
        if (load) begin
          m_steps[i] = 4'd0;
          m_lock[i]  = (seed == 4'd0);
          m_state[i] = (seed == 4'd0) ? 4'd1 : seed;
          m_start[i] = m_state[i];
        end else if (adv) begin
          if (m_state[i] == 4'd0) m_lock[i] = 1'b1;
          m_state[i] = succ4(m_state[i]);
          m_steps[i] = 4'(m_steps[i] + 1);
          m_wrap[i]  = (m_state[i] == m_start[i]);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; mode = 1'b0; step = 1'b0; load = 1'b0;
    clk_edge();
    n_checks++; if (lfsr1 !== 4'd1) begin n_errors++; $display("FAIL reset_lfsr got %h want 1", lfsr1); end
    n_checks++; if (cnt1 !== 4'd0) begin n_errors++; $display("FAIL reset_step_cnt got %0d want 0", cnt1); end
    n_checks++; if (wrap1 !== 1'b0 || lock1 !== 1'b0) begin n_errors++; $display("FAIL reset_flags wrap=%b lockup=%b want 0 0", wrap1, lock1); end
    n_checks++; if (tick1 !== 1'b0 || tick4 !== 1'b0) begin n_errors++; $display("FAIL reset_tick got %b %b want 0 0", tick1, tick4); end
    n_checks++; if (lfsr5 !== 5'd1 || cnt5 !== 5'd0) begin n_errors++; $display("FAIL reset_w5 got %h/%0d want 1/0", lfsr5, cnt5); end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [4:0] s5;
    reset = 1'b1; clk_edge(); reset = 1'b0;
    en = 1'b1; mode = 1'b0; s5 = 5'd1;
    for (int k = 1; k <= 31; k++) begin
      clk_edge();
      s5 = succ5(s5);
      if (k <= 15) begin
        n_checks++; if (lfsr1 !== exp_seq[k]) begin n_errors++; $display("FAIL free_run_seq k=%0d got %h want %h", k, lfsr1, exp_seq[k]); end
        n_checks++; if (wrap1 !== (k == 15)) begin n_errors++; $display("FAIL free_run_wrap k=%0d got %b want %b", k, wrap1, k == 15); end
        n_checks++; if (cnt1 !== 4'(k)) begin n_errors++; $display("FAIL free_run_step_cnt k=%0d got %0d want %0d", k, cnt1, k); end
      end
      n_checks++; if (lfsr1 !== m_state[0] || wrap1 !== m_wrap[0] || tick1 !== 1'b1) begin n_errors++; $display("FAIL free_run_model k=%0d got %h/%b/%b want %h/%b/1", k, lfsr1, wrap1, tick1, m_state[0], m_wrap[0]); end
      n_checks++; if (lfsr5 !== s5 || wrap5 !== (k == 31)) begin n_errors++; $display("FAIL w5_seq k=%0d got %h/%b want %h/%b", k, lfsr5, wrap5, s5, k == 31); end
      n_checks++; if (tick5 !== 1'b1 || lock5 !== 1'b0) begin n_errors++; $display("FAIL w5_flags k=%0d tick=%b lockup=%b want 1 0", k, tick5, lock5); end
    end
    n_checks++; if (lfsr5 !== 5'd1 || cnt5 !== 5'd31) begin n_errors++; $display("FAIL w5_period got %h/%0d want 1/31", lfsr5, cnt5); end
    en = 1'b0;
  endtask

  task automatic test_divider();
    logic [3:0] prev;
    reset = 1'b1; clk_edge(); reset = 1'b0;
    en = 1'b1; mode = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      prev = lfsr4;
      clk_edge();
      n_checks++; if (tick4 !== (k % 4 == 0)) begin n_errors++; $display("FAIL div_tick k=%0d got %b want %b", k, tick4, k % 4 == 0); end
      n_checks++; if ((lfsr4 !== prev) !== tick4 || lfsr4 !== m_state[1]) begin n_errors++; $display("FAIL div_lfsr k=%0d got %h want %h", k, lfsr4, m_state[1]); end
    end
    en = 1'b0;
    prev = lfsr4;
    for (int k = 1; k <= 6; k++) begin
      clk_edge();
      n_checks++; if (tick4 !== 1'b0 || lfsr4 !== prev) begin n_errors++; $display("FAIL div_hold k=%0d tick=%b lfsr=%h want 0 %h", k, tick4, lfsr4, prev); end
    end
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      clk_edge();
      n_checks++; if (tick4 !== (k == 2 || k == 6)) begin n_errors++; $display("FAIL div_resume k=%0d got %b want %b", k, tick4, k == 2 || k == 6); end
    end
    for (int k = 0; k < 40; k++) begin
      en = 1'($urandom_range(0, 3) != 0);
      clk_edge();
      n_checks++; if (tick4 !== m_tick[1] || lfsr4 !== m_state[1] || cnt4 !== m_steps[1]) begin n_errors++; $display("FAIL div_random k=%0d got %b/%h/%0d want %b/%h/%0d", k, tick4, lfsr4, cnt4, m_tick[1], m_state[1], m_steps[1]); end
    end
    en = 1'b0;
  endtask

  task automatic test_single_step();
    int gaps [3] = '{2, 5, 1};
    reset = 1'b1; clk_edge(); reset = 1'b0;
    mode = 1'b1; en = 1'b1; step = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int g = 0; g < gaps[p]; g++) begin
        clk_edge();
        n_checks++; if (lfsr1 !== exp_seq[p] || tick1 !== 1'b0) begin n_errors++; $display("FAIL step_idle p=%0d got %h/%b want %h/0", p, lfsr1, tick1, exp_seq[p]); end
      end
      step = 1'b1; clk_edge(); step = 1'b0;
      n_checks++; if (lfsr1 !== exp_seq[p+1]) begin n_errors++; $display("FAIL step_adv p=%0d got %h want %h", p, lfsr1, exp_seq[p+1]); end
    end
    n_checks++; if (lfsr1 !== 4'd9 || cnt1 !== 4'd3) begin n_errors++; $display("FAIL step_three got %h/%0d want 9/3", lfsr1, cnt1); end
    en = 1'b0; step = 1'b1; clk_edge(); step = 1'b0;
    n_checks++; if (lfsr1 !== 4'd9 || cnt1 !== 4'd3) begin n_errors++; $display("FAIL step_en_low got %h/%0d want 9/3", lfsr1, cnt1); end
    for (int k = 0; k < 40; k++) begin
      en = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      clk_edge();
      n_checks++; if (lfsr1 !== m_state[0] || cnt1 !== m_steps[0] || wrap1 !== m_wrap[0]) begin n_errors++; $display("FAIL step_random k=%0d got %h/%0d/%b want %h/%0d/%b", k, lfsr1, cnt1, wrap1, m_state[0], m_steps[0], m_wrap[0]); end
    end
    step = 1'b0; en = 1'b1;
  endtask

  task automatic test_load();
    mode = 1'b1; en = 1'b1;
    load = 1'b1; seed = 4'b1011; clk_edge(); load = 1'b0;
    n_checks++; if (lfsr1 !== 4'b1011 || cnt1 !== 4'd0) begin n_errors++; $display("FAIL load_value got %h/%0d want b/0", lfsr1, cnt1); end
    for (int k = 1; k <= 15; k++) begin
      step = 1'b1; clk_edge();
      n_checks++; if (lfsr1 !== m_state[0] || wrap1 !== (k == 15)) begin n_errors++; $display("FAIL load_cycle k=%0d got %h/%b want %h/%b", k, lfsr1, wrap1, m_state[0], k == 15); end
    end
    step = 1'b0;
    n_checks++; if (lfsr1 !== 4'b1011 || cnt1 !== 4'd15) begin n_errors++; $display("FAIL load_period got %h/%0d want b/15", lfsr1, cnt1); end
    load = 1'b1; step = 1'b1; seed = 4'b0110; clk_edge(); load = 1'b0; step = 1'b0;
    n_checks++; if (lfsr1 !== 4'b0110 || cnt1 !== 4'd0 || wrap1 !== 1'b0) begin n_errors++; $display("FAIL load_vs_adv got %h/%0d/%b want 6/0/0", lfsr1, cnt1, wrap1); end
  endtask

  task automatic test_zero_seed();
    mode = 1'b1; en = 1'b1;
    load = 1'b1; seed = 4'd0; clk_edge(); load = 1'b0;
    n_checks++; if (lfsr1 !== 4'd1 || lock1 !== 1'b1 || cnt1 !== 4'd0) begin n_errors++; $display("FAIL zero_seed got %h/%b/%0d want 1/1/0", lfsr1, lock1, cnt1); end
    for (int k = 1; k <= 5; k++) begin
      step = 1'b1; clk_edge();
      n_checks++; if (lock1 !== 1'b1 || lfsr1 !== exp_seq[k]) begin n_errors++; $display("FAIL zero_sticky k=%0d got %h/%b want %h/1", k, lfsr1, lock1, exp_seq[k]); end
    end
    step = 1'b0;
    load = 1'b1; seed = 4'b0110; clk_edge(); load = 1'b0;
    n_checks++; if (lock1 !== 1'b0 || lfsr1 !== 4'b0110) begin n_errors++; $display("FAIL zero_clear got %h/%b want 6/0", lfsr1, lock1); end
  endtask

  task automatic test_mid_reset();
    mode = 1'b1; en = 1'b1;
    load = 1'b1; seed = 4'd0; clk_edge(); load = 1'b0;
    mode = 1'b0;
    for (int k = 0; k < 7; k++) clk_edge();
    n_checks++; if (lfsr1 !== exp_seq[7] || lock1 !== 1'b1) begin n_errors++; $display("FAIL mid_pre got %h/%b want %h/1", lfsr1, lock1, exp_seq[7]); end
    reset = 1'b1; clk_edge(); reset = 1'b0;
    n_checks++; if (lfsr1 !== 4'd1 || cnt1 !== 4'd0 || lock1 !== 1'b0 || wrap1 !== 1'b0) begin n_errors++; $display("FAIL mid_reset got %h/%0d/%b/%b want 1/0/0/0", lfsr1, cnt1, lock1, wrap1); end
    n_checks++; if (tick1 !== 1'b0 || tick4 !== 1'b0) begin n_errors++; $display("FAIL mid_reset_tick got %b/%b want 0/0", tick1, tick4); end
    for (int k = 1; k <= 15; k++) begin
      clk_edge();
      n_checks++; if (lfsr1 !== exp_seq[k] || cnt1 !== 4'(k)) begin n_errors++; $display("FAIL mid_restart k=%0d got %h/%0d want %h/%0d", k, lfsr1, cnt1, exp_seq[k], k); end
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      reset = 1'($urandom_range(0, 49) == 0);
      load  = 1'($urandom_range(0, 7) == 0);
      seed  = 4'($urandom_range(0, 15));
      mode  = 1'($urandom_range(0, 3) == 0);
      en    = 1'($urandom_range(0, 4) != 0);
      step  = 1'($urandom_range(0, 1));
      clk_edge();
      for (int i = 0; i < 2; i++) begin
        logic [3:0] g_l, g_c;
        logic       g_t, g_w, g_k;
        g_l = (i == 0) ? lfsr1 : lfsr4; g_c = (i == 0) ? cnt1 : cnt4;
        g_t = (i == 0) ? tick1 : tick4; g_w = (i == 0) ? wrap1 : wrap4; g_k = (i == 0) ? lock1 : lock4;
        n_checks++;
        if (g_l !== m_state[i] || g_c !== m_steps[i] || g_t !== m_tick[i] || g_w !== m_wrap[i] || g_k !== m_lock[i]) begin
          n_errors++;
          $display("FAIL b2b inst=%0d k=%0d got %h/%0d/%b/%b/%b want %h/%0d/%b/%b/%b", i, k, g_l, g_c, g_t, g_w, g_k,
                   m_state[i], m_steps[i], m_tick[i], m_wrap[i], m_lock[i]);
        end
      end
    end
    reset = 1'b0; load = 1'b0; step = 1'b0; en = 1'b0; mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_divider();
    test_single_step();
    test_load();
    test_zero_seed();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the end of the test sequence");
    $fatal(1);
  end

endmodule
